// File: rtl/instr_fetch_ctrl_if.sv
// Fetch-side bus bundle: instruction-memory request/response
// and the fetched-instruction handoff towards decode.
interface instr_fetch_ctrl_if;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_ready;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_resp_valid,
    input  imem_resp_data,
    output if_valid,
    output if_pc,
    output if_instr,
    input  if_ready
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_resp_valid,
    output imem_resp_data,
    input  if_valid,
    input  if_pc,
    input  if_instr,
    output if_ready
  );
endinterface

// File: rtl/instr_fetch_ctrl.sv
// Sequential fetch front-end: owns the PC, keeps one imem read
// in flight and hands each word to decode over valid/ready.
module instr_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stall_i,
  input  logic                      redirect_valid,
  input  logic [31:0]               redirect_pc,
  instr_fetch_ctrl_if.master        bus
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    REQ,
    WAIT,
    HOLD
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic        if_valid_q, if_valid_d;
  logic        drop_q, drop_d;
  logic        req_fire;
  logic        unused_pc_lsb;

  assign unused_pc_lsb = ^redirect_pc[1:0];

  assign bus.imem_req_valid = (state_q == REQ) && !stall_i
                            && !redirect_valid && !rst;
  assign bus.imem_req_addr  = pc_q;
  assign bus.if_valid       = if_valid_q;
  assign bus.if_pc          = if_pc_q;
  assign bus.if_instr       = if_instr_q;

  assign req_fire = bus.imem_req_valid && bus.imem_req_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= REQ;
      pc_q       <= RESET_PC;
      req_pc_q   <= RESET_PC;
      if_pc_q    <= '0;
      if_instr_q <= NOP;
      if_valid_q <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
      if_valid_q <= if_valid_d;
      drop_q     <= drop_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    if_valid_d = if_valid_q;
    drop_d     = drop_q;

    if (redirect_valid) begin
      pc_d       = {redirect_pc[31:2], 2'b00};
      if_valid_d = 1'b0;
      // An outstanding read must still drain; a same-cycle
      // response is that read, so it is dropped right here.
      if ((state_q == WAIT) && !bus.imem_resp_valid) begin
        drop_d  = 1'b1;
        state_d = WAIT;
      end else begin
        drop_d  = 1'b0;
        state_d = REQ;
      end
    end else begin
      unique case (state_q)
        REQ: begin
          if (req_fire) begin
            req_pc_d = pc_q;
            pc_d     = pc_q + PC_STEP;
            state_d  = WAIT;
          end
        end
        WAIT: begin
          if (bus.imem_resp_valid) begin
            if (drop_q) begin
              drop_d  = 1'b0;
              state_d = REQ;
            end else begin
              if_instr_d = bus.imem_resp_data;
              if_pc_d    = req_pc_q;
              if_valid_d = 1'b1;
              state_d    = HOLD;
            end
          end
        end
        HOLD: begin
          if (bus.if_ready && !stall_i) begin
            if_valid_d = 1'b0;
            state_d    = REQ;
          end
        end
        default: begin
          state_d = REQ;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl with a latency-programmable
// memory model and request/handoff scoreboards.
module tb_instr_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'hFFFF_FFFC;

  logic        clk;
  logic        rst;
  logic        stall_i;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  instr_fetch_ctrl_if bus();

  instr_fetch_ctrl #(
    .RESET_PC (RST_PC),
    .PC_STEP  (32'd4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stall_i        (stall_i),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bus            (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          errors = 0;
  int          checks = 0;
  int          budget = 0;
  int          lat    = 1;
  int          cnt    = 0;
  logic [31:0] pend   = '0;
  logic [31:0] req_q[$];
  logic [63:0] out_q[$];

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return (a ^ 32'hA5A5_0000) | 32'h13;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] a);
    req_q.push_back(a);
  endtask

  task automatic push_out(input logic [31:0] a);
    out_q.push_back({a, mem_f(a)});
  endtask

  task automatic cyc_begin();
    logic [31:0] e;
    logic [63:0] o;
    if (cnt == 1) begin
      bus.imem_resp_valid = 1'b1;
      bus.imem_resp_data  = mem_f(pend);
      cnt = 0;
    end else begin
      bus.imem_resp_valid = 1'b0;
      bus.imem_resp_data  = '0;
      if (cnt > 1) cnt--;
    end
    bus.imem_req_ready = (budget != 0);
    @(negedge clk);
    if (bus.imem_req_valid && bus.imem_req_ready) begin
      e = (req_q.size() != 0) ? req_q.pop_front()
                              : ~bus.imem_req_addr;
      chk("req_addr", bus.imem_req_addr, e);
      budget--;
      cnt  = lat;
      pend = bus.imem_req_addr;
    end
    if (bus.if_valid && bus.if_ready && !stall_i) begin
      o = (out_q.size() != 0) ? out_q.pop_front()
                              : ~{bus.if_pc, bus.if_instr};
      chk("if_pc", bus.if_pc, o[63:32]);
      chk("if_instr", bus.if_instr, o[31:0]);
    end
  endtask

  task automatic cyc_end();
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      cyc_begin();
      cyc_end();
    end
  endtask

  initial begin
    rst                 = 1'b1;
    stall_i             = 1'b0;
    redirect_valid      = 1'b0;
    redirect_pc         = '0;
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = '0;
    bus.if_ready        = 1'b0;

    @(posedge clk);
    #1;
    cyc_begin();
    chk("rst_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
    chk("rst_if_valid", {31'b0, bus.if_valid}, 32'd0);
    chk("rst_if_pc", bus.if_pc, 32'h0);
    chk("rst_if_instr", bus.if_instr, 32'h0000_0013);
    cyc_end();
    rst = 1'b0;

    // continuous fetch across the PC wrap
    push(32'hFFFF_FFFC); push(32'h0); push(32'h4); push(32'h8);
    push_out(32'hFFFF_FFFC); push_out(32'h0);
    push_out(32'h4); push_out(32'h8);
    budget = 4;
    bus.if_ready = 1'b1;
    tick(12);
    cyc_begin();
    chk("wrap_next_valid", {31'b0, bus.imem_req_valid}, 32'd1);
    chk("wrap_next_addr", bus.imem_req_addr, 32'hC);
    cyc_end();
    chk("p1_req_left", 32'(req_q.size()), 32'd0);
    chk("p1_out_left", 32'(out_q.size()), 32'd0);

    // back to 0, decode back-pressure for 5 cycles
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0;
    cyc_begin();
    chk("redir_req_gated", {31'b0, bus.imem_req_valid}, 32'd0);
    cyc_end();
    redirect_valid = 1'b0;
    bus.if_ready = 1'b0;
    push(32'h0); push(32'h4);
    push_out(32'h0);
    budget = 2;
    tick(2);
    for (int i = 0; i < 5; i++) begin
      cyc_begin();
      chk("hold_valid", {31'b0, bus.if_valid}, 32'd1);
      chk("hold_instr", bus.if_instr, 32'h0050_0093);
      chk("hold_no_req", {31'b0, bus.imem_req_valid}, 32'd0);
      cyc_end();
    end
    push_out(32'h4);
    bus.if_ready = 1'b1;
    tick(4);
    chk("p2_out_left", 32'(out_q.size()), 32'd0);

    // stall in REQ, then stall while presenting
    stall_i = 1'b1;
    budget  = 1;
    push(32'h8);
    for (int i = 0; i < 3; i++) begin
      cyc_begin();
      chk("stall_no_req", {31'b0, bus.imem_req_valid}, 32'd0);
      cyc_end();
    end
    stall_i = 1'b0;
    push_out(32'h8);
    tick(2);
    stall_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc_begin();
      chk("stall_hold_valid", {31'b0, bus.if_valid}, 32'd1);
      chk("stall_hold_pc", bus.if_pc, 32'h8);
      cyc_end();
    end
    stall_i = 1'b0;
    tick(1);
    chk("p3_out_left", 32'(out_q.size()), 32'd0);

    // redirect while waiting on a slow response for 0xC
    lat    = 3;
    budget = 1;
    push(32'hC);
    tick(1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0102;
    cyc_begin();
    chk("wait_redir_no_req", {31'b0, bus.imem_req_valid}, 32'd0);
    cyc_end();
    redirect_valid = 1'b0;
    tick(1);
    cyc_begin();
    chk("drop_resp_seen", {31'b0, bus.imem_resp_valid}, 32'd1);
    chk("drop_no_valid", {31'b0, bus.if_valid}, 32'd0);
    cyc_end();
    lat    = 1;
    budget = 1;
    push(32'h100);
    push_out(32'h100);
    cyc_begin();
    chk("after_drop_addr", bus.imem_req_addr, 32'h100);
    cyc_end();
    tick(2);
    chk("p4_out_left", 32'(out_q.size()), 32'd0);

    // redirect coincident with memory ready
    budget = 1;
    push(32'h200);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    cyc_begin();
    chk("coinc_no_req", {31'b0, bus.imem_req_valid}, 32'd0);
    cyc_end();
    redirect_valid = 1'b0;
    push_out(32'h200);
    tick(3);
    chk("p5_out_left", 32'(out_q.size()), 32'd0);

    // asynchronous reset while presenting
    bus.if_ready = 1'b0;
    budget = 1;
    push(32'h204);
    push_out(32'h204);
    tick(2);
    cyc_begin();
    chk("pre_rst_valid", {31'b0, bus.if_valid}, 32'd1);
    chk("pre_rst_pc", bus.if_pc, 32'h204);
    #1;
    rst = 1'b1;
    cnt = 0;
    #1;
    chk("async_if_valid", {31'b0, bus.if_valid}, 32'd0);
    chk("async_if_instr", bus.if_instr, 32'h0000_0013);
    chk("async_if_pc", bus.if_pc, 32'h0);
    chk("async_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
    out_q.delete();
    cyc_end();
    rst = 1'b0;
    push(RST_PC);
    push_out(RST_PC);
    budget = 1;
    bus.if_ready = 1'b1;
    tick(3);
    cyc_begin();
    chk("restart_next_addr", bus.imem_req_addr, 32'h0);
    cyc_end();
    chk("end_req_left", 32'(req_q.size()), 32'd0);
    chk("end_out_left", 32'(out_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
